// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path.
// Holds the instruction field layout, opcode and ALU select encodings,
// and the control FSM state codes.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned FIELD_W = 4;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned STATE_W = 3;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LDI  = 4'h6,
    OP_JMP  = 4'h7,
    OP_JZ   = 4'h8,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_PASSB = 3'd5
  } alu_op_t;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_WB     = 3'd3;
  localparam state_t ST_HALT   = 3'd4;

endpackage

// File: rtl/cpu_control_instr_decoder.sv
// Combinational instruction decoder.
// Ports: instr (16-bit instruction word) in; ra1/ra2/a3 register addresses,
// alu_op, imm_sel, imm, and the flags writes_rd/is_jmp/is_jz/is_halt out.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  ra1,
  output logic [3:0]  ra2,
  output logic [3:0]  a3,
  output logic [2:0]  alu_op,
  output logic        imm_sel,
  output logic [7:0]  imm,
  output logic        writes_rd,
  output logic        is_jmp,
  output logic        is_jz,
  output logic        is_halt
);

  logic [3:0] opc;
  logic [3:0] rd;
  logic [3:0] rs1;
  logic [3:0] rs2;

  assign opc = instr[OPC_LSB +: FIELD_W];
  assign rd  = instr[RD_LSB  +: FIELD_W];
  assign rs1 = instr[RS1_LSB +: FIELD_W];
  assign rs2 = instr[RS2_LSB +: FIELD_W];

  // Field decode; reserved opcodes fall through as NOPs.
  always_comb begin
    ra1       = rs1;
    ra2       = rs2;
    a3        = rd;
    alu_op    = ALU_ADD;
    imm_sel   = 1'b0;
    imm       = instr[IMM_W-1:0];
    writes_rd = 1'b0;
    is_jmp    = 1'b0;
    is_jz     = 1'b0;
    is_halt   = 1'b0;
    case (opc)
      OP_ADD: begin alu_op = ALU_ADD; writes_rd = 1'b1; end
      OP_SUB: begin alu_op = ALU_SUB; writes_rd = 1'b1; end
      OP_AND: begin alu_op = ALU_AND; writes_rd = 1'b1; end
      OP_OR:  begin alu_op = ALU_OR;  writes_rd = 1'b1; end
      OP_XOR: begin alu_op = ALU_XOR; writes_rd = 1'b1; end
      OP_LDI: begin
        alu_op    = ALU_PASSB;
        imm_sel   = 1'b1;
        writes_rd = 1'b1;
      end
      OP_JMP:  is_jmp = 1'b1;
      // The tested register sits in the rd field.
      OP_JZ: begin
        ra1   = rd;
        is_jz = 1'b1;
      end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control sequencer: fetch over req/valid, decode, exec, writeback.
// Ports: clk, rst (sync active-high); imem_req/imem_addr/imem_valid/imem_data
// fetch handshake; RA1/RA2/A3/write_enable register-file control; alu_op,
// imm_sel, imm ALU control; rd1 zero-test input; pc and halted status.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic [3:0]      RA1,
  output logic [3:0]      RA2,
  output logic [3:0]      A3,
  output logic            write_enable,
  output logic [2:0]      alu_op,
  output logic            imm_sel,
  output logic [7:0]      imm,
  input  logic [7:0]      rd1,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  state_t          state, state_n;
  logic [PC_W-1:0] pc_q, pc_n;
  logic [15:0]     ir, ir_n;
  logic            req_n;
  logic            we_q, we_n;
  logic            halted_n;
  logic [3:0]      ra1_n, ra2_n, a3_n;
  logic [2:0]      alu_op_n;
  logic            imm_sel_n;
  logic [7:0]      imm_n;

  logic            accept;
  logic [15:0]     dec_in;
  logic [3:0]      dec_ra1, dec_ra2, dec_a3;
  logic [2:0]      dec_alu_op;
  logic            dec_imm_sel;
  logic [7:0]      dec_imm;
  logic            dec_writes_rd, dec_is_jmp, dec_is_jz, dec_is_halt;

  // Response only counts while the request is actually up.
  assign accept = (state == ST_FETCH) && imem_req && imem_valid;

  // Decode the incoming word on accept so the register-file controls are
  // already registered in DECODE; otherwise decode the held IR.
  assign dec_in = accept ? imem_data : ir;

  instr_decoder u_dec (
    .instr     (dec_in),
    .ra1       (dec_ra1),
    .ra2       (dec_ra2),
    .a3        (dec_a3),
    .alu_op    (dec_alu_op),
    .imm_sel   (dec_imm_sel),
    .imm       (dec_imm),
    .writes_rd (dec_writes_rd),
    .is_jmp    (dec_is_jmp),
    .is_jz     (dec_is_jz),
    .is_halt   (dec_is_halt)
  );

  // Next-state, next-pc and registered-output logic.
  always_comb begin
    state_n   = state;
    pc_n      = pc_q;
    ir_n      = ir;
    ra1_n     = RA1;
    ra2_n     = RA2;
    a3_n      = A3;
    alu_op_n  = alu_op;
    imm_sel_n = imm_sel;
    imm_n     = imm;
    case (state)
      ST_FETCH: begin
        if (accept) begin
          ir_n      = imem_data;
          ra1_n     = dec_ra1;
          ra2_n     = dec_ra2;
          a3_n      = dec_a3;
          alu_op_n  = dec_alu_op;
          imm_sel_n = dec_imm_sel;
          imm_n     = dec_imm;
          state_n   = ST_DECODE;
        end
      end
      ST_DECODE: state_n = ST_EXEC;
      ST_EXEC: begin
        if (dec_is_halt) begin
          state_n = ST_HALT;
        end else if (dec_writes_rd) begin
          state_n = ST_WB;
        end else begin
          if (dec_is_jmp || (dec_is_jz && (rd1 == 8'd0))) begin
            pc_n = PC_W'(imm);
          end else begin
            pc_n = pc_q + PC_W'(1);
          end
          state_n = ST_FETCH;
        end
      end
      ST_WB: begin
        pc_n    = pc_q + PC_W'(1);
        state_n = ST_FETCH;
      end
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_FETCH;
    endcase
    req_n    = (state_n == ST_FETCH);
    we_n     = (state_n == ST_WB) && (a3_n != 4'd0);
    halted_n = (state_n == ST_HALT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir       <= 16'h0000;
      imem_req <= 1'b0;
      we_q     <= 1'b0;
      halted   <= 1'b0;
      RA1      <= 4'd0;
      RA2      <= 4'd0;
      A3       <= 4'd0;
      alu_op   <= 3'd0;
      imm_sel  <= 1'b0;
      imm      <= 8'd0;
    end else begin
      state    <= state_n;
      pc_q     <= pc_n;
      ir       <= ir_n;
      imem_req <= req_n;
      we_q     <= we_n;
      halted   <= halted_n;
      RA1      <= ra1_n;
      RA2      <= ra2_n;
      A3       <= a3_n;
      alu_op   <= alu_op_n;
      imm_sel  <= imm_sel_n;
      imm      <= imm_n;
    end
  end

  // Reset must suppress a write already in progress in the same cycle.
  assign write_enable = we_q & ~rst;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_cpu_control.sv
// Directed testbench for cpu_control with a small instruction memory model.
module tb_cpu_control;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [3:0]  RA1, RA2, A3;
  logic        write_enable;
  logic [2:0]  alu_op;
  logic        imm_sel;
  logic [7:0]  imm;
  logic [7:0]  rd1;
  logic [7:0]  pc;
  logic        halted;

  logic [15:0] mem [0:255];
  int          wait_cfg;
  int          wait_cnt;
  int          checks;
  int          errors;

  cpu_control #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_data    (imem_data),
    .RA1          (RA1),
    .RA2          (RA2),
    .A3           (A3),
    .write_enable (write_enable),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .imm          (imm),
    .rd1          (rd1),
    .pc           (pc),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: answers a request after wait_cfg idle cycles.
  always @(negedge clk) begin
    if (imem_req) begin
      if (wait_cnt >= wait_cfg) begin
        imem_valid = 1'b1;
        imem_data  = mem[imem_addr];
      end else begin
        imem_valid = 1'b0;
        wait_cnt   = wait_cnt + 1;
      end
    end else begin
      imem_valid = 1'b0;
      wait_cnt   = 0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", write_enable); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", imem_addr); end
    checks++; if ({RA1, RA2, A3, alu_op, imm_sel, imm} !== 24'h0) begin
      errors++; $display("FAIL reset_fields got %h exp 0", {RA1, RA2, A3, alu_op, imm_sel, imm});
    end
  endtask

  task automatic test_program();
    logic       exp_we;
    logic [3:0] exp_a3;
    logic [2:0] exp_op;
    clear_mem();
    mem[0] = 16'h6105; mem[1] = 16'h6203; mem[2] = 16'h1F12; mem[3] = 16'hF000;
    wait_cfg = 0; rd1 = 8'h00;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp_we = (c == 4) || (c == 8) || (c == 12);
      checks++; if (write_enable !== exp_we) begin errors++; $display("FAIL prog_we cyc %0d got %b exp %b", c, write_enable, exp_we); end
      if (exp_we) begin
        exp_a3 = (c == 4) ? 4'd1 : (c == 8) ? 4'd2 : 4'hF;
        exp_op = (c == 12) ? 3'd0 : 3'd5;
        checks++; if (A3 !== exp_a3) begin errors++; $display("FAIL prog_a3 cyc %0d got %h exp %h", c, A3, exp_a3); end
        checks++; if (alu_op !== exp_op) begin errors++; $display("FAIL prog_aluop cyc %0d got %0d exp %0d", c, alu_op, exp_op); end
        checks++; if (imm_sel !== (c != 12)) begin errors++; $display("FAIL prog_immsel cyc %0d got %b", c, imm_sel); end
      end
      if (c == 4) begin
        checks++; if (imm !== 8'h05) begin errors++; $display("FAIL prog_imm got %h exp 05", imm); end
      end
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL prog_halted got %b exp 1", halted); end
    checks++; if (pc !== 8'h03) begin errors++; $display("FAIL prog_pc got %h exp 03", pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL prog_halt_req got %b exp 0", imem_req); end
  endtask

  task automatic test_mem_wait();
    logic exp_we;
    clear_mem();
    mem[0] = 16'h6105; mem[1] = 16'h6203; mem[2] = 16'hF000;
    wait_cfg = 5;
    do_reset();
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      exp_we = (c == 9) || (c == 18);
      checks++; if (write_enable !== exp_we) begin errors++; $display("FAIL wait_we cyc %0d got %b exp %b", c, write_enable, exp_we); end
      if (c <= 6 || (c >= 10 && c <= 15)) begin
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req cyc %0d got %b exp 1", c, imem_req); end
        checks++; if (imem_addr !== ((c <= 6) ? 8'h00 : 8'h01)) begin
          errors++; $display("FAIL wait_addr cyc %0d got %h", c, imem_addr);
        end
      end
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL wait_halted got %b exp 1", halted); end
    checks++; if (pc !== 8'h02) begin errors++; $display("FAIL wait_pc got %h exp 02", pc); end
    wait_cfg = 0;
  endtask

  task automatic test_jz();
    logic [7:0] exp_pc;
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      mem[0] = 16'h8420;
      rd1 = (k == 0) ? 8'h00 : 8'h07;
      exp_pc = (k == 0) ? 8'h20 : 8'h01;
      do_reset();
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL jz_we k %0d cyc %0d got %b exp 0", k, c, write_enable); end
        if (c == 2) begin
          checks++; if (RA1 !== 4'd4) begin errors++; $display("FAIL jz_ra1 got %h exp 4", RA1); end
        end
        if (c == 3) begin
          checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL jz_exec_req got %b exp 0", imem_req); end
        end
      end
      checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL jz_pc k %0d got %h exp %h", k, imem_addr, exp_pc); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL jz_req k %0d got %b exp 1", k, imem_req); end
    end
    rd1 = 8'h00;
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0] = 16'h70FF; mem[255] = 16'h6009;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL wrap_we cyc %0d got %b exp 0", c, write_enable); end
      if (c == 4) begin
        checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_jmp_addr got %h exp ff", imem_addr); end
      end
      if (c == 7) begin
        checks++; if (A3 !== 4'd0) begin errors++; $display("FAIL wrap_a3 got %h exp 0", A3); end
      end
    end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr got %h exp 00", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req got %b exp 1", imem_req); end
  endtask

  task automatic test_reset_pending();
    clear_mem();
    mem[0] = 16'h6105;
    do_reset();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rstp_req_before got %b exp 1", imem_req); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rstp_req_drop got %b exp 0", imem_req); end
    checks++; if ({RA1, A3, alu_op, imm_sel} !== 12'h0) begin
      errors++; $display("FAIL rstp_fields got %h exp 0", {RA1, A3, alu_op, imm_sel});
    end
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (imem_addr !== 8'h00 || imem_req !== 1'b1) begin
          errors++; $display("FAIL rstp_restart got addr %h req %b exp 00 1", imem_addr, imem_req);
        end
      end
      if (c == 2) begin
        checks++; if (A3 !== 4'd1) begin errors++; $display("FAIL rstp_a3 got %h exp 1", A3); end
      end
      if (c == 4) begin
        checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL rstp_we got %b exp 1", write_enable); end
      end
    end
  endtask

  task automatic test_reset_in_wb();
    clear_mem();
    mem[0] = 16'h6105;
    do_reset();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL rwb_we_before got %b exp 1", write_enable); end
    rst = 1'b1;
    #1;
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rwb_we_reset got %b exp 0", write_enable); end
    @(negedge clk);
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL rwb_pc got %h exp 00", pc); end
  endtask

  task automatic test_reserved();
    clear_mem();
    mem[0] = 16'hA123;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rsv_we cyc %0d got %b exp 0", c, write_enable); end
      if (c == 3) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rsv_exec_req got %b exp 0", imem_req); end
      end
    end
    checks++; if (imem_addr !== 8'h01 || imem_req !== 1'b1) begin
      errors++; $display("FAIL rsv_next got addr %h req %b exp 01 1", imem_addr, imem_req);
    end
  endtask

  initial begin
    rst        = 1'b1;
    imem_valid = 1'b0;
    imem_data  = 16'h0000;
    rd1        = 8'h00;
    wait_cfg   = 0;
    wait_cnt   = 0;
    checks     = 0;
    errors     = 0;
    test_reset();
    test_program();
    test_mem_wait();
    test_jz();
    test_wrap();
    test_reset_pending();
    test_reset_in_wb();
    test_reserved();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
